// File: rtl/sysid_probe.sv
// sysid_probe: Avalon-MM read initiator that fetches the system ID word and
// the build timestamp word, compares them against build-time constants and
// reports pass, fail or bus timeout. Copes with waitrequest stalls and a
// fixed read latency, so it also works with slaves other than the sysid core.
module sysid_probe #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1339225994,
  parameter int unsigned START_DELAY        = 16,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout
);

  typedef enum logic [2:0] {
    INIT,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    CMP,
    DONE
  } state_t;

  // Limits folded to the widths of the counters they are compared against.
  // LAT_LAST is only reachable when READ_LATENCY is non-zero.
  localparam logic [15:0] DELAY_LIMIT   = 16'(START_DELAY);
  localparam logic [2:0]  LAT_LAST      = 3'(READ_LATENCY - 1);
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
  localparam bit          HAS_LATENCY   = (READ_LATENCY != 0);

  state_t      state, state_nxt;
  logic [15:0] dcnt, dcnt_nxt;
  logic [2:0]  lcnt, lcnt_nxt;
  logic [15:0] tcnt, tcnt_nxt;
  logic        read_nxt, addr_nxt;
  logic [31:0] id_nxt, ts_nxt;
  logic        busy_nxt, done_nxt, match_nxt, timeout_nxt;
  logic        stall_expired;

  // State, counters and every output are registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= INIT;
      dcnt            <= '0;
      lcnt            <= '0;
      tcnt            <= '0;
      avm_read        <= 1'b0;
      avm_address     <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      match           <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      state           <= state_nxt;
      dcnt            <= dcnt_nxt;
      lcnt            <= lcnt_nxt;
      tcnt            <= tcnt_nxt;
      avm_read        <= read_nxt;
      avm_address     <= addr_nxt;
      id_value        <= id_nxt;
      timestamp_value <= ts_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      match           <= match_nxt;
      timeout         <= timeout_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_nxt     = state;
    dcnt_nxt      = dcnt;
    lcnt_nxt      = lcnt;
    tcnt_nxt      = tcnt;
    read_nxt      = avm_read;
    addr_nxt      = avm_address;
    id_nxt        = id_value;
    ts_nxt        = timestamp_value;
    busy_nxt      = busy;
    done_nxt      = done;
    match_nxt     = match;
    timeout_nxt   = timeout;
    stall_expired = TIMEOUT_EN && (({1'b0, tcnt} + 17'd1) == TIMEOUT_LIMIT);

    case (state)
      INIT: begin
        busy_nxt = 1'b1;
        if (dcnt == DELAY_LIMIT) begin
          state_nxt = RD_ID;
          read_nxt  = 1'b1;
          addr_nxt  = 1'b0;
        end else begin
          dcnt_nxt = dcnt + 16'd1;
        end
      end

      RD_ID, RD_TS: begin
        if (avm_waitrequest) begin
          if (stall_expired) begin
            state_nxt   = DONE;
            tcnt_nxt    = '0;
            read_nxt    = 1'b0;
            timeout_nxt = 1'b1;
            match_nxt   = 1'b0;
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
          end else begin
            tcnt_nxt = tcnt + 16'd1;
          end
        end else begin
          tcnt_nxt = '0;
          lcnt_nxt = '0;
          if (HAS_LATENCY) begin
            read_nxt  = 1'b0;
            state_nxt = (state == RD_ID) ? LAT_ID : LAT_TS;
          end else if (state == RD_ID) begin
            id_nxt    = avm_readdata;
            state_nxt = RD_TS;
            addr_nxt  = 1'b1;
          end else begin
            ts_nxt    = avm_readdata;
            state_nxt = CMP;
            read_nxt  = 1'b0;
          end
        end
      end

      LAT_ID, LAT_TS: begin
        if (lcnt == LAT_LAST) begin
          lcnt_nxt = '0;
          if (state == LAT_ID) begin
            id_nxt    = avm_readdata;
            state_nxt = RD_TS;
            read_nxt  = 1'b1;
            addr_nxt  = 1'b1;
          end else begin
            ts_nxt    = avm_readdata;
            state_nxt = CMP;
          end
        end else begin
          lcnt_nxt = lcnt + 3'd1;
        end
      end

      CMP: begin
        match_nxt = (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = DONE;
      end

      DONE: begin
        read_nxt = 1'b0;
        if (start) begin
          done_nxt    = 1'b0;
          match_nxt   = 1'b0;
          timeout_nxt = 1'b0;
          busy_nxt    = 1'b1;
          read_nxt    = 1'b1;
          addr_nxt    = 1'b0;
          state_nxt   = RD_ID;
        end
      end

      default: begin
        state_nxt = INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_sysid_probe.sv
// tb_sysid_probe: two probe instances (zero latency with a short timeout, and
// two-cycle read latency) against simple slave models. Expected results are
// queued when each sequence is launched and checked when done rises.
module tb_sysid_probe;

  localparam logic [31:0] GOOD_TS = 32'd1339225994;

  typedef struct {
    logic        match;
    logic        timeout;
    logic [31:0] id;
    logic [31:0] ts;
    int          busy_cycles;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic [31:0] slv_id = 32'd0;
  logic [31:0] slv_ts = GOOD_TS;
  int          stall_len = 0;
  logic        stuck_all = 1'b0;
  logic        stuck_ts = 1'b0;

  logic        addr0, read0, wr0, busy0, done0, match0, to0;
  logic [31:0] rd0, id0, ts0;
  logic        addr1, read1, wr1, busy1, done1, match1, to1;
  logic [31:0] rd1, id1, ts1;
  int          st0, st1;

  exp_t exp0[$];
  exp_t exp1[$];
  int   checkCount = 0;
  int   passCount = 0;

  always #5 clock = ~clock;

  sysid_probe #(
    .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(GOOD_TS),
    .START_DELAY(2), .READ_LATENCY(0), .TIMEOUT_CYCLES(5)
  ) dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wr0), .avm_readdata(rd0),
    .id_value(id0), .timestamp_value(ts0),
    .busy(busy0), .done(done0), .match(match0), .timeout(to0)
  );

  sysid_probe #(
    .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(GOOD_TS),
    .START_DELAY(2), .READ_LATENCY(2), .TIMEOUT_CYCLES(255)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wr1), .avm_readdata(rd1),
    .id_value(id1), .timestamp_value(ts1),
    .busy(busy1), .done(done1), .match(match1), .timeout(to1)
  );

  // Slave models: data follows the held address, stalls last stall_len cycles per read.
  assign wr0 = read0 && (stuck_all || (stuck_ts && addr0) || (st0 < stall_len));
  assign wr1 = read1 && (stuck_all || (stuck_ts && addr1) || (st1 < stall_len));
  assign rd0 = addr0 ? slv_ts : slv_id;
  assign rd1 = addr1 ? slv_ts : slv_id;

  // Stall counters restart for every new read request.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      st0 <= 0;
      st1 <= 0;
    end else begin
      st0 <= (read0 && wr0) ? st0 + 1 : 0;
      st1 <= (read1 && wr1) ? st1 + 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%08h) required %0d (0x%08h)", name, actual, actual, expected, expected);
  endtask

  task automatic checkResult(input string tag, input exp_t e, input logic m, input logic t,
                             input logic [31:0] id, input logic [31:0] ts, input int bc);
    checkOutput({tag, "_match"}, {31'd0, m}, {31'd0, e.match});
    checkOutput({tag, "_timeout"}, {31'd0, t}, {31'd0, e.timeout});
    checkOutput({tag, "_id_value"}, id, e.id);
    checkOutput({tag, "_timestamp_value"}, ts, e.ts);
    checkOutput({tag, "_busy_cycles"}, bc, e.busy_cycles);
  endtask

  // Scoreboard monitor for dut0: pop and compare on each rising done.
  int   bc0;
  logic dq0;
  always @(negedge clock) begin
    if (reset) begin
      bc0 = 0;
      dq0 = 1'b0;
    end else begin
      if (busy0) bc0++;
      if (done0 && !dq0) begin
        if (exp0.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL dut0_unexpected_done: got done=1 required no pending result");
        end else begin
          exp_t e;
          e = exp0.pop_front();
          checkResult("dut0", e, match0, to0, id0, ts0, bc0);
        end
        bc0 = 0;
      end
      dq0 = done0;
    end
  end

  // Scoreboard monitor for dut1.
  int   bc1;
  logic dq1;
  always @(negedge clock) begin
    if (reset) begin
      bc1 = 0;
      dq1 = 1'b0;
    end else begin
      if (busy1) bc1++;
      if (done1 && !dq1) begin
        if (exp1.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL dut1_unexpected_done: got done=1 required no pending result");
        end else begin
          exp_t e;
          e = exp1.pop_front();
          checkResult("dut1", e, match1, to1, id1, ts1, bc1);
        end
        bc1 = 0;
      end
      dq1 = done1;
    end
  end

  // Bus protocol watch: a stalled read keeps read and address unless it timed out.
  logic pr0, pw0, pa0, pr1, pw1, pa1;
  always @(negedge clock) begin
    if (reset) begin
      pr0 = 1'b0; pw0 = 1'b0; pa0 = 1'b0;
      pr1 = 1'b0; pw1 = 1'b0; pa1 = 1'b0;
    end else begin
      if (pr0 && pw0) begin
        checkOutput("dut0_read_held", {31'd0, read0 | to0}, 32'd1);
        checkOutput("dut0_addr_held", {31'd0, addr0}, {31'd0, pa0});
      end
      if (pr1 && pw1) begin
        checkOutput("dut1_read_held", {31'd0, read1 | to1}, 32'd1);
        checkOutput("dut1_addr_held", {31'd0, addr1}, {31'd0, pa1});
      end
      pr0 = read0; pw0 = wr0; pa0 = addr0;
      pr1 = read1; pw1 = wr1; pa1 = addr1;
    end
  end

  function automatic exp_t mkExp(input logic m, input logic t, input logic [31:0] id,
                                 input logic [31:0] ts, input int bc);
    exp_t e;
    e.match = m; e.timeout = t; e.id = id; e.ts = ts; e.busy_cycles = bc;
    return e;
  endfunction

  // Pulse start for one cycle; optionally check the restart took effect on that edge.
  task automatic applyStimulus(input logic s0, input logic s1, input logic chk);
    @(negedge clock);
    start0 = s0;
    start1 = s1;
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
    if (chk && s0) begin
      checkOutput("dut0_restart_done", {31'd0, done0}, 32'd0);
      checkOutput("dut0_restart_match", {31'd0, match0}, 32'd0);
      checkOutput("dut0_restart_timeout", {31'd0, to0}, 32'd0);
      checkOutput("dut0_restart_read", {31'd0, read0}, 32'd1);
      checkOutput("dut0_restart_addr", {31'd0, addr0}, 32'd0);
    end
    if (chk && s1) begin
      checkOutput("dut1_restart_done", {31'd0, done1}, 32'd0);
      checkOutput("dut1_restart_read", {31'd0, read1}, 32'd1);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp0.size() != 0 || exp1.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL wait_idle: got %0d results pending required 0 after %0d cycles",
               exp0.size() + exp1.size(), budget);
      exp0.delete();
      exp1.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic checkAllZero0(input string tag);
    checkOutput({tag, "_read"}, {31'd0, read0}, 32'd0);
    checkOutput({tag, "_addr"}, {31'd0, addr0}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done0}, 32'd0);
    checkOutput({tag, "_match"}, {31'd0, match0}, 32'd0);
    checkOutput({tag, "_timeout"}, {31'd0, to0}, 32'd0);
    checkOutput({tag, "_id"}, id0, 32'd0);
    checkOutput({tag, "_ts"}, ts0, 32'd0);
    checkOutput({tag, "_dut1_busy"}, {31'd0, busy1}, 32'd0);
    checkOutput({tag, "_dut1_ts"}, ts1, 32'd0);
  endtask

  // Bound on total run time in case a sequence wedges the bench.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    logic [5:0] expRead;
    logic [5:0] expAddr;
    logic [5:0] expDone;

    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    checkAllZero0("in_reset");

    // Sysid-style slave straight out of reset.
    exp0.push_back(mkExp(1'b1, 1'b0, 32'd0, GOOD_TS, 5));
    exp1.push_back(mkExp(1'b1, 1'b0, 32'd0, GOOD_TS, 9));
    expRead = 6'b001100;
    expAddr = 6'b111000;
    expDone = 6'b100000;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checkOutput($sformatf("first_run_read_e%0d", k + 1), {31'd0, read0}, {31'd0, expRead[k]});
      checkOutput($sformatf("first_run_addr_e%0d", k + 1), {31'd0, addr0}, {31'd0, expAddr[k]});
      checkOutput($sformatf("first_run_done_e%0d", k + 1), {31'd0, done0}, {31'd0, expDone[k]});
    end
    waitIdle(40);

    // Wrong timestamp word.
    slv_ts = GOOD_TS + 32'd1;
    exp0.push_back(mkExp(1'b0, 1'b0, 32'd0, GOOD_TS + 32'd1, 3));
    exp1.push_back(mkExp(1'b0, 1'b0, 32'd0, GOOD_TS + 32'd1, 7));
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitIdle(40);

    // Three waitrequest cycles on every read.
    slv_ts = GOOD_TS;
    stall_len = 3;
    exp0.push_back(mkExp(1'b1, 1'b0, 32'd0, GOOD_TS, 9));
    exp1.push_back(mkExp(1'b1, 1'b0, 32'd0, GOOD_TS, 13));
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitIdle(60);
    stall_len = 0;

    // Waitrequest stuck high from the ID read: nothing captured.
    stuck_all = 1'b1;
    slv_id = 32'hDEADBEEF;
    exp0.push_back(mkExp(1'b0, 1'b1, 32'd0, GOOD_TS, 5));
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitIdle(40);
    stuck_all = 1'b0;

    // Stuck only on the timestamp read: new ID kept, old timestamp kept.
    stuck_ts = 1'b1;
    slv_id = 32'h12345678;
    exp0.push_back(mkExp(1'b0, 1'b1, 32'h12345678, GOOD_TS, 6));
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitIdle(40);
    stuck_ts = 1'b0;
    slv_id = 32'd0;

    // Restart from DONE, then a start pulse while busy that must be ignored.
    exp0.push_back(mkExp(1'b1, 1'b0, 32'd0, GOOD_TS, 3));
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle(40);
    repeat (8) @(negedge clock);
    checkOutput("ignored_start_busy", {31'd0, busy0}, 32'd0);
    checkOutput("ignored_start_done", {31'd0, done0}, 32'd1);

    // Reset while dut0 is in RD_TS, then a full rerun including the INIT delay.
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clock);
    checkOutput("pre_reset_in_rd_ts_addr", {31'd0, addr0}, 32'd1);
    checkOutput("pre_reset_in_rd_ts_read", {31'd0, read0}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkAllZero0("mid_reset");
    exp0.push_back(mkExp(1'b1, 1'b0, 32'd0, GOOD_TS, 5));
    exp1.push_back(mkExp(1'b1, 1'b0, 32'd0, GOOD_TS, 9));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    waitIdle(40);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
